instr_fetch_fsm: RTL and testbench

INSTR_FETCH_FSM -- requirements
Module: instr_fetch_fsm

---
 rtl/instr_fetch_fsm.sv | 163 ++++++++++++++++
 tb/tb_instr_fetch_fsm.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_fsm
//  Description : Instruction fetch/decode/dispatch controller. Fetches 16-bit
//                words from a latency-1 synchronous memory, decodes them, and
//                dispatches ALU ops to a downstream sequencer. A 4-bit
//                watchdog guards the wait for completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_fsm (
    input  logic        clk,
    input  logic        reset,
    input  logic        run_i,
    input  logic [15:0] mem_data_i,
    input  logic        alu_done_i,
    output logic [7:0]  mem_addr_o,
    output logic        mem_rd_o,
    output logic [3:0]  opcode_o,
    output logic [5:0]  ri_o,
    output logic [5:0]  rj_o,
    output logic        alu_start_o,
    output logic [7:0]  pc_o,
    output logic        halted_o,
    output logic        illegal_o,
    output logic        timeout_o
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_LOAD     = 3'd2,
        S_DECODE   = 3'd3,
        S_DISPATCH = 3'd4,
        S_WAIT     = 3'd5,
        S_INCR     = 3'd6,
        S_HALT     = 3'd7
    } state_t;

    localparam logic [1:0] CLS_ALU  = 2'd0;
    localparam logic [1:0] CLS_HALT = 2'd1;
    localparam logic [1:0] CLS_ILL  = 2'd2;
    localparam logic [5:0] REG_MAX  = 6'd4;
    localparam logic [3:0] WDOG_MAX = 4'hF;

    state_t      state_q;
    logic [15:0] ir_q;
    logic [7:0]  pc_q;
    logic [3:0]  wdog_q;
    logic        mem_rd_q;
    logic        alu_start_q;
    logic        illegal_q;
    logic        halted_q;
    logic        timeout_q;

    // Instruction class: ALU ops need opcode[3]=0 and both register indices
    // within 0..4; 4'hF halts; everything else is undecodable.
    function automatic logic [1:0] classify(input logic [15:0] w);
        if (w[15:12] == 4'hF)
            classify = CLS_HALT;
        else if (!w[15] && (w[11:6] <= REG_MAX) && (w[5:0] <= REG_MAX))
            classify = CLS_ALU;
        else
            classify = CLS_ILL;
    endfunction

    // Main controller: state, IR, pc, watchdog and all registered strobes.
    // Strobes are set on the transition into the state they belong to so
    // they are high exactly during that state. The illegal flag is computed
    // from the word being loaded so it coincides with the DECODE cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ir_q        <= 16'h0000;
            pc_q        <= 8'h00;
            wdog_q      <= 4'h0;
            mem_rd_q    <= 1'b0;
            alu_start_q <= 1'b0;
            illegal_q   <= 1'b0;
            halted_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            mem_rd_q    <= 1'b0;
            alu_start_q <= 1'b0;
            illegal_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (run_i) begin
                        state_q  <= S_FETCH;
                        mem_rd_q <= 1'b1;
                    end
                end
                S_FETCH: begin
                    state_q <= S_LOAD;
                end
                S_LOAD: begin
                    ir_q      <= mem_data_i;
                    illegal_q <= (classify(mem_data_i) == CLS_ILL);
                    state_q   <= S_DECODE;
                end
                S_DECODE: begin
                    case (classify(ir_q))
                        CLS_ALU: begin
                            state_q     <= S_DISPATCH;
                            alu_start_q <= 1'b1;
                        end
                        CLS_HALT: begin
                            state_q  <= S_HALT;
                            halted_q <= 1'b1;
                        end
                        default: begin
                            state_q <= S_INCR;
                        end
                    endcase
                end
                S_DISPATCH: begin
                    wdog_q  <= 4'h0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // Completion takes priority over a watchdog expiring in
                    // the same cycle.
                    if (alu_done_i) begin
                        state_q <= S_INCR;
                    end else if (wdog_q == WDOG_MAX) begin
                        timeout_q <= 1'b1;
                        halted_q  <= 1'b1;
                        state_q   <= S_HALT;
                    end else begin
                        wdog_q <= wdog_q + 4'd1;
                    end
                end
                S_INCR: begin
                    pc_q <= pc_q + 8'd1;
                    if (run_i) begin
                        state_q  <= S_FETCH;
                        mem_rd_q <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_addr_o  = pc_q;
    assign mem_rd_o    = mem_rd_q;
    assign opcode_o    = ir_q[15:12];
    assign ri_o        = ir_q[11:6];
    assign rj_o        = ir_q[5:0];
    assign alu_start_o = alu_start_q;
    assign pc_o        = pc_q;
    assign halted_o    = halted_q;
    assign illegal_o   = illegal_q;
    assign timeout_o   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_fsm
//  Description : Directed self-checking bench for instr_fetch_fsm with a
//                latency-1 instruction memory and a delay-programmable ALU
//                responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_fsm;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        run_i = 1'b0;
    logic [15:0] mem_data_i = 16'h0000;
    logic        alu_done_i = 1'b0;
    logic [7:0]  mem_addr_o;
    logic        mem_rd_o;
    logic [3:0]  opcode_o;
    logic [5:0]  ri_o;
    logic [5:0]  rj_o;
    logic        alu_start_o;
    logic [7:0]  pc_o;
    logic        halted_o;
    logic        illegal_o;
    logic        timeout_o;

    instr_fetch_fsm dut (
        .clk         (clk),
        .reset       (reset),
        .run_i       (run_i),
        .mem_data_i  (mem_data_i),
        .alu_done_i  (alu_done_i),
        .mem_addr_o  (mem_addr_o),
        .mem_rd_o    (mem_rd_o),
        .opcode_o    (opcode_o),
        .ri_o        (ri_o),
        .rj_o        (rj_o),
        .alu_start_o (alu_start_o),
        .pc_o        (pc_o),
        .halted_o    (halted_o),
        .illegal_o   (illegal_o),
        .timeout_o   (timeout_o)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;

    logic [15:0] mem [256];
    logic        rd_pend = 1'b0;
    logic [7:0]  pend_addr = 8'h00;
    int          alu_delay = 0;
    int          alu_cnt = 0;

    int          cyc, n_fetch, n_start, n_ill, unstable;
    int          fetch_cyc [4];
    logic [7:0]  last_addr, addr256;
    logic        in_win;
    logic [15:0] win_fields, start_fields;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        cyc = 0; n_fetch = 0; n_start = 0; n_ill = 0; unstable = 0;
        in_win = 1'b0; win_fields = 16'h0; start_fields = 16'h0;
        last_addr = 8'h00; addr256 = 8'h00;
        for (int i = 0; i < 4; i++) fetch_cyc[i] = 0;
    endtask

    // One clock: models respond and monitors sample at the falling edge.
    task automatic step();
        @(negedge clk);
        mem_data_i = rd_pend ? mem[pend_addr] : 16'hDEAD;
        rd_pend    = mem_rd_o;
        pend_addr  = mem_addr_o;
        alu_done_i = 1'b0;
        if (alu_cnt > 0) begin
            alu_cnt--;
            if (alu_cnt == 0) alu_done_i = 1'b1;
        end
        if (alu_start_o && alu_delay > 0) alu_cnt = alu_delay;
        cyc++;
        if (in_win && ({opcode_o, ri_o, rj_o} != win_fields)) unstable++;
        if (alu_start_o) begin
            n_start++;
            in_win = 1'b1;
            win_fields = {opcode_o, ri_o, rj_o};
            start_fields = win_fields;
        end
        if (illegal_o) n_ill++;
        if (mem_rd_o) begin
            in_win = 1'b0;
            if (n_fetch < 4) fetch_cyc[n_fetch] = cyc;
            n_fetch++;
            last_addr = mem_addr_o;
            if (n_fetch == 256) addr256 = mem_addr_o;
        end
    endtask

    task automatic do_reset(input logic run_v);
        @(negedge clk);
        reset = 1'b1; run_i = run_v; alu_done_i = 1'b0; alu_cnt = 0;
        rd_pend = 1'b0; mem_data_i = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        clear_mon();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pc"},      pc_o,        0);
        chk({tag, "_addr"},    mem_addr_o,  0);
        chk({tag, "_rd"},      mem_rd_o,    0);
        chk({tag, "_ir"},      {opcode_o, ri_o, rj_o}, 0);
        chk({tag, "_start"},   alu_start_o, 0);
        chk({tag, "_illegal"}, illegal_o,   0);
        chk({tag, "_halted"},  halted_o,    0);
        chk({tag, "_timeout"}, timeout_o,   0);
    endtask

    task automatic wait_start(input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            step();
            if (alu_start_o) found = 1'b1;
        end
        chk(tag, found, 1);
    endtask

    initial begin
        int k;
        for (int i = 0; i < 256; i++) mem[i] = 16'h7042;
        clear_mon();

        // Asynchronous reset with no clock edge.
        #1 reset = 1'b1;
        #1 chk_reset("rst0");

        // Program: ALU op, illegal op, HALT.
        mem[1] = 16'h8000;
        mem[2] = 16'hF000;
        alu_delay = 6;
        do_reset(1'b1);
        step();
        chk("first_rd",   mem_rd_o,   1);
        chk("first_addr", mem_addr_o, 0);
        for (int i = 0; i < 200 && !halted_o; i++) step();
        chk("prog_halted",  halted_o, 1);
        chk("prog_starts",  n_start, 1);
        chk("prog_fields",  start_fields, 16'h7042);
        chk("prog_stable",  unstable, 0);
        chk("prog_lat_alu", fetch_cyc[1] - fetch_cyc[0], 11);
        chk("prog_lat_ill", fetch_cyc[2] - fetch_cyc[1], 4);
        chk("prog_illegal", n_ill, 1);
        chk("prog_fetches", n_fetch, 3);
        chk("prog_pc",      pc_o, 2);
        chk("prog_timeout", timeout_o, 0);
        for (int i = 0; i < 20; i++) step();
        chk("halt_fetches", n_fetch, 3);
        chk("halt_sticky",  halted_o, 1);
        chk("halt_pc",      pc_o, 2);
        mem[1] = 16'h7042;
        mem[2] = 16'h7042;

        // Watchdog expiry with no completion.
        alu_delay = 0;
        do_reset(1'b1);
        wait_start("to_start");
        k = 0;
        for (int i = 0; i < 40 && !halted_o; i++) begin
            step();
            k++;
        end
        chk("to_cycles",  k, 17);
        chk("to_timeout", timeout_o, 1);
        chk("to_halted",  halted_o, 1);
        chk("to_pc",      pc_o, 0);

        // Completion on the final watchdog cycle wins.
        alu_delay = 16;
        do_reset(1'b1);
        for (int i = 0; i < 60 && n_fetch < 2; i++) step();
        chk("edge_fetch2",  n_fetch, 2);
        chk("edge_addr",    last_addr, 1);
        chk("edge_timeout", timeout_o, 0);
        chk("edge_halted",  halted_o, 0);
        chk("edge_pc",      pc_o, 1);

        // Run dropped mid-WAIT, then reset mid-WAIT.
        alu_delay = 6;
        do_reset(1'b1);
        wait_start("rd_start");
        step();
        run_i = 1'b0;
        for (int i = 0; i < 30; i++) step();
        chk("rd_fetches", n_fetch, 1);
        chk("rd_pc",      pc_o, 1);
        chk("rd_halted",  halted_o, 0);
        run_i = 1'b1;
        step();
        chk("rd_restart", mem_rd_o, 1);
        chk("rd_raddr",   mem_addr_o, 1);
        wait_start("rw_start");
        step();
        step();
        #1 reset = 1'b1;
        #1 chk_reset("rst_wait");

        // pc wraps from 255 to 0.
        alu_delay = 1;
        do_reset(1'b1);
        for (int i = 0; i < 2000 && n_fetch < 257; i++) step();
        chk("wrap_fetches", n_fetch, 257);
        chk("wrap_addr255", addr256, 8'hFF);
        chk("wrap_addr0",   last_addr, 0);
        chk("wrap_pc",      pc_o, 0);
        chk("wrap_starts",  n_start, 256);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
